// File: rtl/hp_ctrl_multi.sv
// hp_ctrl_multi: per-channel hit-point controller for N_CH independent players.
// Each channel takes damage from DMG_PIX, heals on the rising edge of
// HEAL_PIX, becomes invulnerable for INV_CYCLES after a hit, and locks at
// HP 0. Channels only meet in all_dead.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (overrides restart)
//   restart      synchronous game restart for all channels
//   current_pix  [4*N_CH-1:0]    pixel code under channel i at [4i+3:4i]
//   hp_numb      [HP_W*N_CH-1:0] registered HP of channel i
//   hit_pulse    [N_CH-1:0]      one-cycle damage strobe
//   invuln       [N_CH-1:0]      channel is invulnerable
//   dead         [N_CH-1:0]      channel HP is 0 and locked
//   all_dead                     AND of dead

// hp_ch: one channel; same ports as above for a single lane.
module hp_ch #(
    parameter int         HP_W       = 4,
    parameter int         HP_INIT    = 9,
    parameter int         HP_MAX     = 9,
    parameter int         INV_CYCLES = 50000000,
    parameter logic [3:0] DMG_PIX    = 4'h5,
    parameter logic [3:0] HEAL_PIX   = 4'hA
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic [3:0]      pix,
    output logic [HP_W-1:0] hp,
    output logic            hit_pulse,
    output logic            invuln,
    output logic            dead
);
    typedef enum logic [1:0] {IDLE, DEC, INV, DEAD} state_t;

    localparam int              TW     = $clog2(INV_CYCLES) + 1;
    localparam logic [TW-1:0]   T_LAST = TW'(INV_CYCLES - 1);
    localparam logic [HP_W-1:0] HP_I   = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] HP_M   = HP_W'(HP_MAX);

    state_t          state, state_nxt;
    logic [HP_W-1:0] hp_nxt, hp_inc;
    logic [TW-1:0]   timer, timer_nxt;
    logic            heal_prev, heal_ev, hit_nxt;

    // Heal acts on the first cycle HEAL_PIX appears, not while it is held.
    assign heal_ev = (pix == HEAL_PIX) && !heal_prev;
    assign hp_inc  = (hp >= HP_M) ? hp : hp + HP_W'(1);

    always_comb begin
        state_nxt = state;
        hp_nxt    = hp;
        timer_nxt = timer;
        hit_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pix == DMG_PIX) begin
                    state_nxt = DEC;
                    hp_nxt    = (hp == '0) ? '0 : hp - HP_W'(1);
                    hit_nxt   = 1'b1;
                end else if (heal_ev) begin
                    hp_nxt = hp_inc;
                end
            end
            DEC: begin
                // hp here is already the decremented value
                timer_nxt = '0;
                state_nxt = (hp == '0) ? DEAD : INV;
            end
            INV: begin
                if (heal_ev) hp_nxt = hp_inc;
                if (timer == T_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DEAD:    hp_nxt = '0;
            default: state_nxt = IDLE;
        endcase
    end

    // rst and restart have identical effect, so rst overriding restart is implicit.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state     <= IDLE;
            hp        <= HP_I;
            timer     <= '0;
            heal_prev <= 1'b0;
            hit_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            hp        <= hp_nxt;
            timer     <= timer_nxt;
            heal_prev <= (pix == HEAL_PIX);
            hit_pulse <= hit_nxt;
        end
    end

    assign invuln = (state == INV);
    assign dead   = (state == DEAD);
endmodule

module hp_ctrl_multi #(
    parameter int         N_CH       = 2,
    parameter int         HP_W       = 4,
    parameter int         HP_INIT    = 9,
    parameter int         HP_MAX     = 9,
    parameter int         INV_CYCLES = 50000000,
    parameter logic [3:0] DMG_PIX    = 4'h5,
    parameter logic [3:0] HEAL_PIX   = 4'hA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic [4*N_CH-1:0]    current_pix,
    output logic [HP_W*N_CH-1:0] hp_numb,
    output logic [N_CH-1:0]      hit_pulse,
    output logic [N_CH-1:0]      invuln,
    output logic [N_CH-1:0]      dead,
    output logic                 all_dead
);
    if (N_CH < 1) begin : g_bad_nch
        $error("hp_ctrl_multi: N_CH must be at least 1");
    end
    if (HP_INIT > HP_MAX || HP_MAX > (1 << HP_W) - 1) begin : g_bad_hp
        $error("hp_ctrl_multi: need HP_INIT <= HP_MAX <= 2^HP_W-1");
    end
    if (INV_CYCLES < 1) begin : g_bad_inv
        $error("hp_ctrl_multi: INV_CYCLES must be at least 1");
    end
    if (DMG_PIX == HEAL_PIX) begin : g_bad_pix
        $error("hp_ctrl_multi: DMG_PIX and HEAL_PIX must differ");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        hp_ch #(
            .HP_W       (HP_W),
            .HP_INIT    (HP_INIT),
            .HP_MAX     (HP_MAX),
            .INV_CYCLES (INV_CYCLES),
            .DMG_PIX    (DMG_PIX),
            .HEAL_PIX   (HEAL_PIX)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .restart   (restart),
            .pix       (current_pix[4*i +: 4]),
            .hp        (hp_numb[HP_W*i +: HP_W]),
            .hit_pulse (hit_pulse[i]),
            .invuln    (invuln[i]),
            .dead      (dead[i])
        );
    end

    assign all_dead = &dead;
endmodule
